multicycle_controller: RTL and testbench
========================================

// Module: multicycle_controller
// PURPOSE
//  Multi-cycle control unit for the RV32I core.
//  - Sequences each instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK. A Moore FSM drives the datapath enables.
//  - Supports the R, I, U (LUI), LW, SW, BEQ-class branch and JALR opcodes.
//  - Adds wait-state handshakes for instruction and data memory, an external stall, a memory timeout, and a sticky trap for illegal opcodes.
// PARAMETERS
//  OPCODE_W     7   opcode field width
//  ALUOP_W      2   ALU-op bus width (00 LW/SW add, 01 branch, 10 R/I, 11 LUI)
//  MEM_TIMEOUT  15  max cycles spent waiting for instr_valid/mem_ready before trap (>=1)
// PORTS
//  clk            in   1          rising-edge clock
//  reset_n        in   1          asynchronous active-low reset
//  opcode         in   OPCODE_W   opcode from instruction register; valid from DECODE onward
//  instr_valid    in   1          instruction memory returned data this cycle
//  mem_ready      in   1          data memory completed the read/write this cycle
//  stall          in   1          external hold request
//  instr_req      out  1          fetch request to instruction memory
//  ir_write       out  1          load instruction register (one-cycle pulse)
//  pc_write       out  1          unconditional PC update (PC+4 or jump target)
//  pc_write_cond  out  1          PC update if ALU zero (branch)
//  alu_src_a      out  1          0: PC, 1: rs1
//  alu_src_b      out  2          00 rs2, 01 const 4, 10 immediate
//  alu_op         out  ALUOP_W    ALU-op code as listed above
//  mem_read       out  1          data memory read strobe
//  mem_write      out  1          data memory write strobe
//  mem_to_reg     out  2          00 ALU result, 01 memory data, 10 PC+4
//  reg_write      out  1          register file write enable
//  jsel           out  1          jump target = ALU result (JALR)
//  illegal_instr  out  1          sticky: unknown opcode decoded
//  mem_timeout    out  1          sticky: memory handshake exceeded MEM_TIMEOUT
//  busy           out  1          1 in every state except IDLE and TRAP
// BEHAVIOUR
//  - Reset (async, reset_n=0):
//    - State goes to IDLE and both sticky flags clear.
//    - Every output is 0 until one cycle after release, then IDLE->FETCH.
//  - Outputs are pure decodes of the state register (Moore). The next state is registered.
//  - Per-state outputs (unlisted outputs are 0):
//    - FETCH: instr_req=1. Holds while instr_valid=0. On instr_valid: ir_write=1, pc_write=1, alu_src_a=0, alu_src_b=01 in the same cycle, then ->DECODE.
//    - DECODE: alu_src_a=0, alu_src_b=10, alu_op=00 (branch target precompute). Next state depends on opcode:
//      - R (0110011) or I (0010011) or U (0110111) -> EXEC
//      - LW/SW -> ADDR
//      - BR (1100011) -> BRANCH
//      - JALR (1100111) -> JUMP
//      - anything else -> TRAP
//    - EXEC: alu_src_a=1. alu_src_b=00 for R, 10 for I/U. alu_op=10 for R/I, 11 for U. ->WB_ALU.
//    - WB_ALU: reg_write=1, mem_to_reg=00, ->FETCH.
//    - ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. ->MEM_RD (LW) or MEM_WR (SW).
//    - MEM_RD: mem_read=1. Holds until mem_ready, then ->WB_MEM.
//    - WB_MEM: reg_write=1, mem_to_reg=01, ->FETCH.
//    - MEM_WR: mem_write=1. Holds until mem_ready, then ->FETCH.
//    - BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1. ->FETCH.
//    - JUMP: jsel=1, pc_write=1, reg_write=1, mem_to_reg=10, alu_src_a=1, alu_src_b=10. ->FETCH.
//    - TRAP: all strobes 0, busy=0. Held until reset.
//  - Minimum cycles per instruction, with zero wait states:
//    - BR/JALR: 3
//    - R/I/U/SW: 4
//    - LW: 5
//  - Wait timer:
//    - Counter is cleared on entry to FETCH, MEM_RD or MEM_WR and increments each waiting cycle.
//    - When it reaches MEM_TIMEOUT without a handshake: set mem_timeout, ->TRAP.
//    - A handshake arriving in the same cycle as the limit wins, so there is no trap.
//  - illegal_instr is set in the DECODE cycle that selects TRAP.
//  - stall=1 handling:
//    - In FETCH, DECODE, EXEC, ADDR, BRANCH, JUMP, WB_*: the FSM and timer freeze, and ir_write, pc_write, pc_write_cond, reg_write are forced to 0 for that cycle.
//    - stall is ignored in MEM_RD/MEM_WR, so an in-flight memory access is never aborted.
//    - In FETCH, a stall in the same cycle as instr_valid is ignored as well: the fetch completes and the FSM moves to DECODE. This prevents a lost fetch.
//  - The opcode is sampled only in DECODE, EXEC and ADDR. Changes in other states have no effect.
// STRUCTURE
//  - Package riscv_ctrl_pkg holds:
//    - state_t enum
//    - opcode localparams
//    - ALU-op, alu_src_b and mem_to_reg encodings
//  - Sub-module mem_wait_timer (params MEM_TIMEOUT; ports clk, reset_n, clear, en, expired) implements the wait counter.
//  - The FSM state register is the only other sequential logic.
// TESTING
//  1. Reset release, instr_valid=1, opcode=0110011, mem_ready=1 -> IDLE,FETCH,DECODE,EXEC,WB_ALU. reg_write=1 only in cycle 5, alu_op=10.
//  2. LW with mem_ready delayed 3 cycles -> mem_read high for exactly 4 cycles, then WB_MEM with mem_to_reg=01, reg_write=1.
//  3. BEQ then JALR -> pc_write_cond=1 for 1 cycle, alu_op=01. JUMP asserts jsel=1, pc_write=1, mem_to_reg=10. Each takes 3 cycles.
//  4. opcode=7'b1111111 in DECODE -> illegal_instr=1, busy=0, TRAP persists 20 cycles. reset_n pulse -> flags cleared, FSM back in IDLE.
//  5. instr_valid held 0 for MEM_TIMEOUT=15 cycles -> mem_timeout=1 and TRAP. Repeat with instr_valid on cycle 15 -> no trap, DECODE.
//  6. stall=1 for 2 cycles in EXEC of addi -> state frozen, no reg_write. stall during MEM_WR -> ignored, completes on mem_ready.
//  7. reset_n asserted mid-MEM_WR -> mem_write=0 immediately (async), IDLE.

Source files
------------

// File: rtl/multicycle_controller_pkg.sv
// ----------------------------------------------------------------------------
// riscv_ctrl_pkg
// Shared types and encodings for the RV32I multi-cycle control unit:
//   state_t      controller FSM states
//   OP_*         RV32I major opcodes the controller understands
//   ALUOP_*      ALU-op bus encodings
//   SRCB_*       alu_src_b mux selects
//   M2R_*        mem_to_reg mux selects
// ----------------------------------------------------------------------------
package riscv_ctrl_pkg;

   typedef enum logic [3:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_WB_ALU,
      S_ADDR,
      S_MEM_RD,
      S_WB_MEM,
      S_MEM_WR,
      S_BRANCH,
      S_JUMP,
      S_TRAP
   } state_t;

   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_I    = 7'b0010011;
   localparam logic [6:0] OP_LUI  = 7'b0110111;
   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_BR   = 7'b1100011;
   localparam logic [6:0] OP_JALR = 7'b1100111;

   localparam logic [1:0] ALUOP_ADD    = 2'b00;
   localparam logic [1:0] ALUOP_BRANCH = 2'b01;
   localparam logic [1:0] ALUOP_FUNC   = 2'b10;
   localparam logic [1:0] ALUOP_LUI    = 2'b11;

   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_FOUR = 2'b01;
   localparam logic [1:0] SRCB_IMM  = 2'b10;

   localparam logic [1:0] M2R_ALU = 2'b00;
   localparam logic [1:0] M2R_MEM = 2'b01;
   localparam logic [1:0] M2R_PC4 = 2'b10;

endpackage

// File: rtl/multicycle_controller_if.sv
// ----------------------------------------------------------------------------
// multicycle_controller_if
// Bundle between the control unit and the datapath / memories.
//   master : the controller (drives datapath enables and memory strobes)
//   slave  : datapath + memory side (drives opcode and handshakes)
// Signals: opcode, instr_valid, mem_ready, stall (to controller);
//   instr_req, ir_write, pc_write, pc_write_cond, alu_src_a, alu_src_b,
//   alu_op, mem_read, mem_write, mem_to_reg, reg_write, jsel,
//   illegal_instr, mem_timeout, busy (from controller).
// ----------------------------------------------------------------------------
interface multicycle_controller_if #(
   parameter int OPCODE_W = 7,
   parameter int ALUOP_W  = 2
);
   logic [OPCODE_W-1:0] opcode;
   logic                instr_valid;
   logic                mem_ready;
   logic                stall;
   logic                instr_req;
   logic                ir_write;
   logic                pc_write;
   logic                pc_write_cond;
   logic                alu_src_a;
   logic [1:0]          alu_src_b;
   logic [ALUOP_W-1:0]  alu_op;
   logic                mem_read;
   logic                mem_write;
   logic [1:0]          mem_to_reg;
   logic                reg_write;
   logic                jsel;
   logic                illegal_instr;
   logic                mem_timeout;
   logic                busy;

   modport master (
      input  opcode, instr_valid, mem_ready, stall,
      output instr_req, ir_write, pc_write, pc_write_cond, alu_src_a,
             alu_src_b, alu_op, mem_read, mem_write, mem_to_reg,
             reg_write, jsel, illegal_instr, mem_timeout, busy
   );

   modport slave (
      output opcode, instr_valid, mem_ready, stall,
      input  instr_req, ir_write, pc_write, pc_write_cond, alu_src_a,
             alu_src_b, alu_op, mem_read, mem_write, mem_to_reg,
             reg_write, jsel, illegal_instr, mem_timeout, busy
   );
endinterface

// File: rtl/multicycle_controller_timer.sv
// ----------------------------------------------------------------------------
// mem_wait_timer
// Counts cycles spent waiting on a memory handshake.
//   clk, reset_n : clock, asynchronous active-low reset
//   clear        : restart the count (has priority over en)
//   en           : one more waiting cycle has elapsed
//   expired      : the current cycle is the MEM_TIMEOUT-th waiting cycle
// ----------------------------------------------------------------------------
module mem_wait_timer #(
   parameter int MEM_TIMEOUT = 15
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clear,
   input  logic en,
   output logic expired
);
   localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

   logic [CNT_W-1:0] cnt;

   // cnt holds the number of waiting cycles already completed, so the
   // MEM_TIMEOUT-th waiting cycle is the one where cnt == MEM_TIMEOUT-1.
   assign expired = (cnt == CNT_W'(MEM_TIMEOUT - 1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (en && !expired) begin
         cnt <= cnt + 1'b1;
      end
   end
endmodule

// File: rtl/multicycle_controller.sv
// ----------------------------------------------------------------------------
// multicycle_controller
// Multi-cycle control unit for the RV32I core. Sequences each instruction
// through fetch / decode / execute / memory / writeback and drives the
// datapath enables, with wait-state handshakes, external stall, memory
// timeout and sticky traps.
//   clk      : rising-edge clock
//   reset_n  : asynchronous active-low reset
//   bus      : controller side (master) of multicycle_controller_if
// ----------------------------------------------------------------------------
module multicycle_controller
   import riscv_ctrl_pkg::*;
#(
   parameter int OPCODE_W    = 7,
   parameter int ALUOP_W     = 2,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic                    clk,
   input  logic                    reset_n,
   multicycle_controller_if.master bus
);
   state_t state, next_state;
   logic   illegal_q, timeout_q;
   logic   set_illegal, set_timeout;
   logic   tmr_clear, tmr_en, tmr_expired;
   logic   is_r, is_i, is_u, is_lw, is_sw, is_br, is_jalr;

   assign is_r    = (bus.opcode == OPCODE_W'(OP_R));
   assign is_i    = (bus.opcode == OPCODE_W'(OP_I));
   assign is_u    = (bus.opcode == OPCODE_W'(OP_LUI));
   assign is_lw   = (bus.opcode == OPCODE_W'(OP_LW));
   assign is_sw   = (bus.opcode == OPCODE_W'(OP_SW));
   assign is_br   = (bus.opcode == OPCODE_W'(OP_BR));
   assign is_jalr = (bus.opcode == OPCODE_W'(OP_JALR));

   // Any state change restarts the count, which covers entry into every
   // waiting state. A stalled fetch freezes the count; memory waits never do.
   assign tmr_clear = (next_state != state);
   assign tmr_en    = (next_state == state) &&
                      ((state == S_FETCH && !bus.stall) ||
                       state == S_MEM_RD || state == S_MEM_WR);

   mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (tmr_clear),
      .en      (tmr_en),
      .expired (tmr_expired)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= S_IDLE;
         illegal_q <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state <= next_state;
         if (set_illegal) illegal_q <= 1'b1;
         if (set_timeout) timeout_q <= 1'b1;
      end
   end

   always_comb begin
      next_state  = state;
      set_illegal = 1'b0;
      set_timeout = 1'b0;
      case (state)
         S_IDLE: next_state = S_FETCH;
         // A returning fetch wins over both stall and the timeout limit.
         S_FETCH: begin
            if (bus.instr_valid) begin
               next_state = S_DECODE;
            end else if (!bus.stall && tmr_expired) begin
               next_state  = S_TRAP;
               set_timeout = 1'b1;
            end
         end
         S_DECODE: begin
            if (!bus.stall) begin
               if (is_r || is_i || is_u)  next_state = S_EXEC;
               else if (is_lw || is_sw)   next_state = S_ADDR;
               else if (is_br)            next_state = S_BRANCH;
               else if (is_jalr)          next_state = S_JUMP;
               else begin
                  next_state  = S_TRAP;
                  set_illegal = 1'b1;
               end
            end
         end
         S_EXEC:   if (!bus.stall) next_state = S_WB_ALU;
         S_ADDR:   if (!bus.stall) next_state = is_sw ? S_MEM_WR : S_MEM_RD;
         S_WB_ALU, S_WB_MEM, S_BRANCH, S_JUMP:
                   if (!bus.stall) next_state = S_FETCH;
         S_MEM_RD, S_MEM_WR: begin
            if (bus.mem_ready) begin
               next_state = (state == S_MEM_RD) ? S_WB_MEM : S_FETCH;
            end else if (tmr_expired) begin
               next_state  = S_TRAP;
               set_timeout = 1'b1;
            end
         end
         S_TRAP:   next_state = S_TRAP;
         default:  next_state = S_IDLE;
      endcase
   end

   // State-driven enables; register/PC writes are suppressed while stalled.
   always_comb begin
      bus.instr_req     = 1'b0;
      bus.ir_write      = 1'b0;
      bus.pc_write      = 1'b0;
      bus.pc_write_cond = 1'b0;
      bus.alu_src_a     = 1'b0;
      bus.alu_src_b     = SRCB_RS2;
      bus.alu_op        = ALUOP_W'(ALUOP_ADD);
      bus.mem_read      = 1'b0;
      bus.mem_write     = 1'b0;
      bus.mem_to_reg    = M2R_ALU;
      bus.reg_write     = 1'b0;
      bus.jsel          = 1'b0;
      case (state)
         S_FETCH: begin
            bus.instr_req = 1'b1;
            if (bus.instr_valid) begin
               bus.ir_write  = 1'b1;
               bus.pc_write  = 1'b1;
               bus.alu_src_b = SRCB_FOUR;
            end
         end
         S_DECODE: bus.alu_src_b = SRCB_IMM;
         S_EXEC: begin
            bus.alu_src_a = 1'b1;
            bus.alu_src_b = is_r ? SRCB_RS2 : SRCB_IMM;
            bus.alu_op    = is_u ? ALUOP_W'(ALUOP_LUI) : ALUOP_W'(ALUOP_FUNC);
         end
         S_WB_ALU: bus.reg_write = !bus.stall;
         S_ADDR: begin
            bus.alu_src_a = 1'b1;
            bus.alu_src_b = SRCB_IMM;
         end
         S_MEM_RD: bus.mem_read  = 1'b1;
         S_MEM_WR: bus.mem_write = 1'b1;
         S_WB_MEM: begin
            bus.reg_write  = !bus.stall;
            bus.mem_to_reg = M2R_MEM;
         end
         S_BRANCH: begin
            bus.alu_src_a     = 1'b1;
            bus.alu_op        = ALUOP_W'(ALUOP_BRANCH);
            bus.pc_write_cond = !bus.stall;
         end
         S_JUMP: begin
            bus.jsel       = 1'b1;
            bus.pc_write   = !bus.stall;
            bus.reg_write  = !bus.stall;
            bus.mem_to_reg = M2R_PC4;
            bus.alu_src_a  = 1'b1;
            bus.alu_src_b  = SRCB_IMM;
         end
         default: ;
      endcase
      bus.illegal_instr = illegal_q;
      bus.mem_timeout   = timeout_q;
      bus.busy          = (state != S_IDLE) && (state != S_TRAP);
   end
endmodule

// File: tb/tb_multicycle_controller.sv
// ----------------------------------------------------------------------------
// tb_multicycle_controller
// Self-checking bench for multicycle_controller. Expected behaviour is
// expressed as a per-cycle plan built instruction by instruction from the
// documented cycle sequences; each planned cycle carries both the inputs to
// drive and the outputs required in that cycle.
// ----------------------------------------------------------------------------
module tb_multicycle_controller;

   typedef struct packed {
      logic       instr_req;
      logic       ir_write;
      logic       pc_write;
      logic       pc_write_cond;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic       mem_read;
      logic       mem_write;
      logic [1:0] mem_to_reg;
      logic       reg_write;
      logic       jsel;
      logic       illegal_instr;
      logic       mem_timeout;
      logic       busy;
   } out_t;

   typedef struct packed {
      logic       iv;
      logic       mr;
      logic       st;
      logic [6:0] op;
      out_t       exp;
   } vec_t;

   localparam int C_R = 0, C_I = 1, C_U = 2, C_LW = 3, C_SW = 4, C_BR = 5, C_JALR = 6;
   localparam logic [6:0] OPC [0:6] = '{7'b0110011, 7'b0010011, 7'b0110111,
                                        7'b0000011, 7'b0100011, 7'b1100011, 7'b1100111};

   logic clk     = 1'b0;
   logic reset_n = 1'b1;
   int   checks   = 0;
   int   failures = 0;
   vec_t plan[$];
   vec_t tbl [0:10];

   multicycle_controller_if #(.OPCODE_W(7), .ALUOP_W(2)) bus ();

   multicycle_controller #(.OPCODE_W(7), .ALUOP_W(2), .MEM_TIMEOUT(15)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   // Required outputs for each step of an instruction (st = stalled cycle)
   function automatic out_t e_fetch(bit v);
      out_t o = '0;
      o.busy = 1'b1; o.instr_req = 1'b1;
      if (v) begin o.ir_write = 1'b1; o.pc_write = 1'b1; o.alu_src_b = 2'b01; end
      return o;
   endfunction
   function automatic out_t e_dec();
      out_t o = '0;
      o.busy = 1'b1; o.alu_src_b = 2'b10;
      return o;
   endfunction
   function automatic out_t e_exec(int cls);
      out_t o = '0;
      o.busy = 1'b1; o.alu_src_a = 1'b1;
      o.alu_src_b = (cls == C_R) ? 2'b00 : 2'b10;
      o.alu_op    = (cls == C_U) ? 2'b11 : 2'b10;
      return o;
   endfunction
   function automatic out_t e_wb_alu(bit st);
      out_t o = '0;
      o.busy = 1'b1; o.reg_write = !st;
      return o;
   endfunction
   function automatic out_t e_addr();
      out_t o = '0;
      o.busy = 1'b1; o.alu_src_a = 1'b1; o.alu_src_b = 2'b10;
      return o;
   endfunction
   function automatic out_t e_mrd();
      out_t o = '0;
      o.busy = 1'b1; o.mem_read = 1'b1;
      return o;
   endfunction
   function automatic out_t e_mwr();
      out_t o = '0;
      o.busy = 1'b1; o.mem_write = 1'b1;
      return o;
   endfunction
   function automatic out_t e_wb_mem(bit st);
      out_t o = '0;
      o.busy = 1'b1; o.reg_write = !st; o.mem_to_reg = 2'b01;
      return o;
   endfunction
   function automatic out_t e_br(bit st);
      out_t o = '0;
      o.busy = 1'b1; o.alu_src_a = 1'b1; o.alu_op = 2'b01; o.pc_write_cond = !st;
      return o;
   endfunction
   function automatic out_t e_jmp(bit st);
      out_t o = '0;
      o.busy = 1'b1; o.jsel = 1'b1; o.pc_write = !st; o.reg_write = !st;
      o.mem_to_reg = 2'b10; o.alu_src_a = 1'b1; o.alu_src_b = 2'b10;
      return o;
   endfunction
   function automatic out_t e_trap(bit ill, bit to);
      out_t o = '0;
      o.illegal_instr = ill; o.mem_timeout = to;
      return o;
   endfunction

   function automatic vec_t mkv(logic iv, logic mr, logic st, logic [6:0] op, out_t e);
      vec_t v;
      v.iv = iv; v.mr = mr; v.st = st; v.op = op; v.exp = e;
      return v;
   endfunction

   function automatic logic rb();
      return 1'($urandom);
   endfunction
   function automatic logic [6:0] rop();
      return 7'($urandom);
   endfunction

   function automatic void push(logic iv, logic mr, logic st, logic [6:0] op, out_t e);
      plan.push_back(mkv(iv, mr, st, op, e));
   endfunction

   // n stalled cycles followed by the cycle that completes the step
   function automatic void phase(int n, logic [6:0] op, bit junk_op, out_t es, out_t er);
      for (int i = 0; i < n; i++) push(rb(), rb(), 1'b1, junk_op ? rop() : op, es);
      push(rb(), rb(), 1'b0, junk_op ? rop() : op, er);
   endfunction

   function automatic void plan_instr(int cls, int fw, int mw, int smax);
      logic [6:0] op = OPC[cls];
      for (int i = 0; i < fw; i++) push(1'b0, rb(), rb(), rop(), e_fetch(1'b0));
      push(1'b1, rb(), rb(), rop(), e_fetch(1'b1));
      phase($urandom_range(0, smax), op, 1'b0, e_dec(), e_dec());
      case (cls)
         C_R, C_I, C_U: begin
            phase($urandom_range(0, smax), op, 1'b0, e_exec(cls), e_exec(cls));
            phase($urandom_range(0, smax), op, 1'b1, e_wb_alu(1'b1), e_wb_alu(1'b0));
         end
         C_LW, C_SW: begin
            phase($urandom_range(0, smax), op, 1'b0, e_addr(), e_addr());
            for (int i = 0; i < mw; i++)
               push(rb(), 1'b0, rb(), rop(), (cls == C_LW) ? e_mrd() : e_mwr());
            push(rb(), 1'b1, rb(), rop(), (cls == C_LW) ? e_mrd() : e_mwr());
            if (cls == C_LW)
               phase($urandom_range(0, smax), op, 1'b1, e_wb_mem(1'b1), e_wb_mem(1'b0));
         end
         C_BR:    phase($urandom_range(0, smax), op, 1'b1, e_br(1'b1), e_br(1'b0));
         default: phase($urandom_range(0, smax), op, 1'b1, e_jmp(1'b1), e_jmp(1'b0));
      endcase
   endfunction

   function automatic out_t get_out();
      out_t o;
      o.instr_req     = bus.instr_req;
      o.ir_write      = bus.ir_write;
      o.pc_write      = bus.pc_write;
      o.pc_write_cond = bus.pc_write_cond;
      o.alu_src_a     = bus.alu_src_a;
      o.alu_src_b     = bus.alu_src_b;
      o.alu_op        = bus.alu_op;
      o.mem_read      = bus.mem_read;
      o.mem_write     = bus.mem_write;
      o.mem_to_reg    = bus.mem_to_reg;
      o.reg_write     = bus.reg_write;
      o.jsel          = bus.jsel;
      o.illegal_instr = bus.illegal_instr;
      o.mem_timeout   = bus.mem_timeout;
      o.busy          = bus.busy;
      return o;
   endfunction

   task automatic check(string name, out_t act, out_t exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: outputs got %b required %b", name, act, exp);
      end
   endtask

   // Entered and left just after a rising edge; outputs sampled on the falling edge.
   task automatic apply(vec_t v, string name);
      bus.instr_valid = v.iv;
      bus.mem_ready   = v.mr;
      bus.stall       = v.st;
      bus.opcode      = v.op;
      @(negedge clk);
      check(name, get_out(), v.exp);
      @(posedge clk);
      #1;
   endtask

   task automatic run_plan(string name);
      foreach (plan[i]) apply(plan[i], $sformatf("%s[%0d]", name, i));
      plan.delete();
   endtask

   task automatic do_reset(string name);
      bus.instr_valid = 1'b0;
      bus.mem_ready   = 1'b0;
      bus.stall       = 1'b0;
      reset_n         = 1'b0;
      #1;
      check(name, get_out(), '0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   initial begin
      bus.instr_valid = 1'b0;
      bus.mem_ready   = 1'b0;
      bus.stall       = 1'b0;
      bus.opcode      = '0;

      // R-type, then BEQ, then JALR at zero wait states
      tbl[0]  = mkv(1, 1, 0, OPC[C_R],    '0);
      tbl[1]  = mkv(1, 1, 0, OPC[C_R],    e_fetch(1'b1));
      tbl[2]  = mkv(1, 1, 0, OPC[C_R],    e_dec());
      tbl[3]  = mkv(1, 1, 0, OPC[C_R],    e_exec(C_R));
      tbl[4]  = mkv(1, 1, 0, OPC[C_R],    e_wb_alu(1'b0));
      tbl[5]  = mkv(1, 1, 0, OPC[C_BR],   e_fetch(1'b1));
      tbl[6]  = mkv(1, 1, 0, OPC[C_BR],   e_dec());
      tbl[7]  = mkv(1, 1, 0, OPC[C_BR],   e_br(1'b0));
      tbl[8]  = mkv(1, 1, 0, OPC[C_JALR], e_fetch(1'b1));
      tbl[9]  = mkv(1, 1, 0, OPC[C_JALR], e_dec());
      tbl[10] = mkv(1, 1, 0, OPC[C_JALR], e_jmp(1'b0));

      #2;
      do_reset("reset_initial");
      for (int i = 0; i < 11; i++) apply(tbl[i], $sformatf("tbl[%0d]", i));

      // LW with data memory ready after three wait cycles
      plan_instr(C_LW, 0, 3, 0);
      run_plan("lw_wait3");

      // addi stalled two cycles in EXEC, then SW stalled throughout MEM_WR
      push(1, 0, 0, rop(), e_fetch(1'b1));
      push(0, 0, 0, OPC[C_I], e_dec());
      push(0, 0, 1, OPC[C_I], e_exec(C_I));
      push(0, 0, 1, OPC[C_I], e_exec(C_I));
      push(0, 0, 0, OPC[C_I], e_exec(C_I));
      push(0, 0, 0, rop(), e_wb_alu(1'b0));
      push(1, 0, 1, rop(), e_fetch(1'b1));
      push(0, 0, 0, OPC[C_SW], e_dec());
      push(0, 0, 0, OPC[C_SW], e_addr());
      push(0, 0, 1, rop(), e_mwr());
      push(0, 0, 1, rop(), e_mwr());
      push(0, 1, 1, rop(), e_mwr());
      plan_instr(C_R, 0, 0, 0);
      run_plan("stall");

      // Illegal opcode: sticky trap until reset
      push(1, 0, 0, rop(), e_fetch(1'b1));
      push(0, 0, 0, 7'b1111111, e_dec());
      for (int i = 0; i < 20; i++) push(rb(), rb(), rb(), rop(), e_trap(1'b1, 1'b0));
      run_plan("illegal");
      do_reset("reset_after_illegal");

      // Fetch timeout at exactly 15 waiting cycles
      push(0, 0, 0, rop(), '0);
      for (int i = 0; i < 15; i++) push(0, rb(), 0, rop(), e_fetch(1'b0));
      for (int i = 0; i < 3; i++) push(rb(), rb(), rb(), rop(), e_trap(1'b0, 1'b1));
      run_plan("fetch_timeout");
      do_reset("reset_after_fetch_timeout");

      // Fetch completing on the 15th cycle beats the limit
      push(0, 0, 0, rop(), '0);
      for (int i = 0; i < 14; i++) push(0, rb(), 0, rop(), e_fetch(1'b0));
      plan_instr(C_R, 0, 0, 0);
      run_plan("fetch_limit");

      // Data-memory read that never completes
      push(1, 0, 0, rop(), e_fetch(1'b1));
      push(0, 0, 0, OPC[C_LW], e_dec());
      push(0, 0, 0, OPC[C_LW], e_addr());
      for (int i = 0; i < 15; i++) push(rb(), 0, rb(), rop(), e_mrd());
      for (int i = 0; i < 3; i++) push(rb(), rb(), rb(), rop(), e_trap(1'b0, 1'b1));
      run_plan("mem_timeout");
      do_reset("reset_after_mem_timeout");

      // Random instruction stream with random wait states and stalls
      push(rb(), rb(), rb(), rop(), '0);
      for (int i = 0; i < 60; i++)
         plan_instr($urandom_range(0, 6), $urandom_range(0, 4), $urandom_range(0, 4), 2);
      run_plan("rand");

      // Reset arriving while a store is waiting on memory
      push(1, 0, 0, rop(), e_fetch(1'b1));
      push(0, 0, 0, OPC[C_SW], e_dec());
      push(0, 0, 0, OPC[C_SW], e_addr());
      push(0, 0, 0, rop(), e_mwr());
      push(0, 0, 0, rop(), e_mwr());
      run_plan("sw_pre_reset");
      bus.mem_ready = 1'b0;
      bus.stall     = 1'b1;
      #1;
      check("memwr_live", get_out(), e_mwr());
      reset_n = 1'b0;
      #1;
      check("memwr_async_reset", get_out(), '0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      push(rb(), rb(), rb(), rop(), '0);
      plan_instr(C_BR, 1, 0, 1);
      run_plan("after_reset");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
